// File: rtl/counter_sequencer_if.sv
// Control/status bundle between register logic and counter_sequencer.
// master drives start/stop/pause/mode/term/presc; slave returns q/tc/busy/done.
// With COUNTER_SEQ_CAPTURE_EN: adds cap (to slave), cap_q and cap_vld (from slave).
interface counter_sequencer_if #(
  parameter int WIDTH      = 8,
  parameter int PRESC_BITS = 4
);
  logic                  start;
  logic                  stop;
  logic                  pause;
  logic                  mode;
  logic [WIDTH-1:0]      term;
  logic [PRESC_BITS-1:0] presc;
  logic [WIDTH-1:0]      q;
  logic                  tc;
  logic                  busy;
  logic                  done;
`ifdef COUNTER_SEQ_CAPTURE_EN
  logic                  cap;
  logic [WIDTH-1:0]      cap_q;
  logic                  cap_vld;
`endif

  modport master (
`ifdef COUNTER_SEQ_CAPTURE_EN
    output cap,
    input  cap_q,
    input  cap_vld,
`endif
    output start,
    output stop,
    output pause,
    output mode,
    output term,
    output presc,
    input  q,
    input  tc,
    input  busy,
    input  done
  );

  modport slave (
`ifdef COUNTER_SEQ_CAPTURE_EN
    input  cap,
    output cap_q,
    output cap_vld,
`endif
    input  start,
    input  stop,
    input  pause,
    input  mode,
    input  term,
    input  presc,
    output q,
    output tc,
    output busy,
    output done
  );
endinterface

// File: rtl/counter_sequencer.sv
// Run controller for a mod-(term+1) up-counter with prescaler,
// one-shot/periodic modes, pause, and terminal-count pulse.
// Ports: clk, rst (async active-high), bus (counter_sequencer_if.slave).
// Optional macro COUNTER_SEQ_CAPTURE_EN adds cap -> cap_q/cap_vld capture.
module counter_sequencer #(
  parameter int WIDTH      = 8,
  parameter int PRESC_BITS = 4
) (
  input logic               clk,
  input logic               rst,
  counter_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    DONE
  } state_t;

  state_t                state, state_n;
  logic [WIDTH-1:0]      q, q_n;
  logic [WIDTH-1:0]      term_l, term_n;
  logic [PRESC_BITS-1:0] pcnt, pcnt_n;
  logic [PRESC_BITS-1:0] presc_l, presc_n;
  logic                  mode_l, mode_n;
  logic                  tc, tc_n;
  logic                  busy, busy_n;
  logic                  done, done_n;
  logic                  step_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      q       <= '0;
      term_l  <= '0;
      pcnt    <= '0;
      presc_l <= '0;
      mode_l  <= 1'b0;
      tc      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      q       <= q_n;
      term_l  <= term_n;
      pcnt    <= pcnt_n;
      presc_l <= presc_n;
      mode_l  <= mode_n;
      tc      <= tc_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    q_n     = q;
    term_n  = term_l;
    pcnt_n  = pcnt;
    presc_n = presc_l;
    mode_n  = mode_l;
    tc_n    = 1'b0;
    step_en = 1'b0;
    if (bus.stop) begin
      state_n = IDLE;
      q_n     = '0;
      pcnt_n  = '0;
    end else if (bus.start) begin
      state_n = RUN;
      q_n     = '0;
      pcnt_n  = '0;
      term_n  = bus.term;
      presc_n = bus.presc;
      mode_n  = bus.mode;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.pause) state_n = HOLD;
          else step_en = 1'b1;
        end
        // The release edge counts, so the
        // delay equals the paused cycles.
        HOLD: begin
          if (!bus.pause) begin
            state_n = RUN;
            step_en = 1'b1;
          end
        end
        default: ;
      endcase
      if (step_en) begin
        if (pcnt == presc_l) begin
          pcnt_n = '0;
          if (q == term_l) begin
            tc_n = 1'b1;
            if (mode_l) q_n = '0;
            else state_n = DONE;
          end else begin
            q_n = q + WIDTH'(1);
          end
        end else begin
          pcnt_n = pcnt + PRESC_BITS'(1);
        end
      end
    end
    busy_n = (state_n == RUN) || (state_n == HOLD);
    done_n = (state_n == DONE);
  end

  assign bus.q    = q;
  assign bus.tc   = tc;
  assign bus.busy = busy;
  assign bus.done = done;

`ifdef COUNTER_SEQ_CAPTURE_EN
  logic             cap_r;
  logic             cap_d;
  logic [WIDTH-1:0] cap_q;
  logic             cap_vld;

  // cap_r samples the pin, cap_d delays it:
  // rising edge is seen one edge after sampling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_r   <= 1'b0;
      cap_d   <= 1'b0;
      cap_q   <= '0;
      cap_vld <= 1'b0;
    end else begin
      cap_r   <= bus.cap;
      cap_d   <= cap_r;
      cap_vld <= 1'b0;
      if (cap_r && !cap_d && busy) begin
        cap_q   <= q;
        cap_vld <= 1'b1;
      end
    end
  end

  assign bus.cap_q   = cap_q;
  assign bus.cap_vld = cap_vld;
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer.
// Steps: reset, one-shot, periodic+pause, stop/start, edge values, capture.
module tb_counter_sequencer;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;
  int   tc_cnt;

  counter_sequencer_if #(.WIDTH(8), .PRESC_BITS(4)) bus ();

  counter_sequencer #(
    .WIDTH(8),
    .PRESC_BITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic arm(input logic [7:0] t, input logic [3:0] p,
                     input logic m);
    bus.term  = t;
    bus.presc = p;
    bus.mode  = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.pause = 1'b0;
    bus.mode  = 1'b0;
    bus.term  = '0;
    bus.presc = '0;
`ifdef COUNTER_SEQ_CAPTURE_EN
    bus.cap   = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_q", bus.q, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_tc", bus.tc, 0);

    // One-shot term=3 presc=1
    arm(8'd3, 4'd1, 1'b0);
    chk("os_busy", bus.busy, 1);
    chk("os_q0", bus.q, 0);
    tick();
    chk("os_q_k1", bus.q, 0);
    tick();
    chk("os_q_k2", bus.q, 1);
    tick();
    tick();
    chk("os_q_k4", bus.q, 2);
    tick();
    tick();
    chk("os_q_k6", bus.q, 3);
    tick();
    chk("os_tc_k7", bus.tc, 0);
    tick();
    chk("os_tc_k8", bus.tc, 1);
    chk("os_done_k8", bus.done, 1);
    chk("os_busy_k8", bus.busy, 0);
    chk("os_q_k8", bus.q, 3);
    tick();
    chk("os_tc_k9", bus.tc, 0);
    chk("os_q_k9", bus.q, 3);
    chk("os_done_k9", bus.done, 1);

    // Re-arm from DONE, then async reset at q=5
    arm(8'd10, 4'd0, 1'b0);
    chk("rearm_done", bus.done, 0);
    repeat (5) tick();
    chk("pre_rst_q", bus.q, 5);
    rst = 1'b1;
    #1;
    chk("async_q", bus.q, 0);
    chk("async_busy", bus.busy, 0);
    chk("async_done", bus.done, 0);
    chk("async_tc", bus.tc, 0);
    #2;
    rst = 1'b0;
    tick();

    // Periodic term=4 presc=0 with pause
    arm(8'd4, 4'd0, 1'b1);
    repeat (4) tick();
    chk("per_q4", bus.q, 4);
    chk("per_tc_k4", bus.tc, 0);
    tick();
    chk("per_tc_k5", bus.tc, 1);
    chk("per_q_k5", bus.q, 0);
    repeat (4) tick();
    chk("per_tc_k9", bus.tc, 0);
    tick();
    chk("per_tc_k10", bus.tc, 1);
    tick();
    tick();
    chk("per_q_k12", bus.q, 2);
    bus.pause = 1'b1;
    tc_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.tc) tc_cnt++;
      chk("hold_q", bus.q, 2);
      chk("hold_busy", bus.busy, 1);
    end
    chk("hold_no_tc", tc_cnt, 0);
    bus.pause = 1'b0;
    tick();
    chk("resume_q", bus.q, 3);
    tick();
    chk("resume_tc_k21", bus.tc, 0);
    tick();
    chk("resume_tc_k22", bus.tc, 1);
    chk("resume_q_k22", bus.q, 0);

    // Stop+start together at q=2
    arm(8'd9, 4'd0, 1'b1);
    tick();
    tick();
    chk("ss_pre_q", bus.q, 2);
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    chk("ss_q", bus.q, 0);
    chk("ss_busy", bus.busy, 0);
    tick();
    chk("ss_idle_q", bus.q, 0);

    // Restart in RUN at q=3
    arm(8'd9, 4'd0, 1'b1);
    repeat (3) tick();
    chk("rs_pre_q", bus.q, 3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("rs_q", bus.q, 0);
    chk("rs_busy", bus.busy, 1);
    chk("rs_tc", bus.tc, 0);
    tick();
    chk("rs_run_q", bus.q, 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;

    // term=0 presc=0: tc every cycle
    arm(8'd0, 4'd0, 1'b1);
    chk("t0_tc_start", bus.tc, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t0_tc", bus.tc, 1);
      chk("t0_q", bus.q, 0);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("stop_tc", bus.tc, 0);

    // term=255 presc=15: first tc 4096 cycles after start
    arm(8'd255, 4'd15, 1'b1);
    tc_cnt = 0;
    for (int i = 1; i < 4096; i++) begin
      tick();
      if (bus.tc) tc_cnt++;
    end
    chk("big_no_early_tc", tc_cnt, 0);
    chk("big_q_max", bus.q, 255);
    tick();
    chk("big_tc", bus.tc, 1);
    chk("big_wrap_q", bus.q, 0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;

`ifdef COUNTER_SEQ_CAPTURE_EN
    // Capture at q=7 with presc=3
    arm(8'd20, 4'd3, 1'b0);
    repeat (28) tick();
    chk("cap_pre_q", bus.q, 7);
    bus.cap = 1'b1;
    tick();
    chk("cap_vld_1", bus.cap_vld, 0);
    tick();
    chk("cap_vld_2", bus.cap_vld, 1);
    chk("cap_q_2", bus.cap_q, 7);
    tick();
    chk("cap_vld_3", bus.cap_vld, 0);
    chk("cap_q_3", bus.cap_q, 7);
    bus.cap  = 1'b0;
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    tick();
    bus.cap = 1'b1;
    tc_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.cap_vld) tc_cnt++;
    end
    chk("cap_idle_vld", tc_cnt, 0);
    chk("cap_idle_q", bus.cap_q, 7);
    bus.cap = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Run controller for a mod-(TERM+1) up-counter datapath.
- Provides start, stop and pause control, one-shot or periodic mode, and a programmable prescaler.
- Emits a terminal-count pulse and done status.
- Sits between the register/control logic and the timing consumers. It replaces free-running counters wherever software must arm, pause or re-arm a timer.

Parameters:
WIDTH, 8, counter and terminal-value width in bits (>=1)
PRESC_BITS, 4, prescaler reload width; prescale ratio = presc+1 (1..2**PRESC_BITS)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  arm request, sampled each clk edge
stop  in  1  abort request, sampled each clk edge
pause  in  1  level; freezes counting while high
mode  in  1  0 = one-shot, 1 = periodic (latched on start)
term  in  WIDTH  terminal count value (latched on start)
presc  in  PRESC_BITS  prescale reload (latched on start)
q  out  WIDTH  current count
tc  out  1  one-cycle pulse when count reaches terminal
busy  out  1  high in RUN or HOLD
done  out  1  high in DONE (one-shot completed)

Behaviour:
- Reset (async, rst=1): state=IDLE; q=0; tc=0; busy=0; done=0; prescaler=0; latched term/presc/mode=0.
- States: IDLE, RUN, HOLD, DONE. All outputs are registered.
- Priority at each edge: stop > start > pause > counting.
- IDLE:
  - start=1 latches term, presc and mode; clears q and the prescaler; next state RUN.
  - busy=1 from the same edge.
- RUN:
  - Prescaler counts 0..presc_l. On the edge where prescaler==presc_l it wraps to 0 and a count step occurs.
  - Count step with q != term_l: q <= q+1.
  - Count step with q == term_l: tc=1 for exactly that cycle.
    - Periodic: q <= 0, stay RUN.
    - One-shot: q holds term_l, go to DONE.
- First increment latency: start sampled at edge k gives q=1 after edge k+presc_l+1.
- Period: tc repeats every (term_l+1)*(presc_l+1) cycles in periodic mode.
- term=0: tc fires on every count step; q stays 0.
- presc=0: a step occurs every cycle.
- pause=1 in RUN: go to HOLD. q and the prescaler freeze; no tc.
- HOLD with pause=0: return to RUN and resume from the frozen prescaler value, with no lost or extra steps.
- DONE: done=1, busy=0, q holds term_l.
  - start re-arms with freshly latched values: q=0, go to RUN.
  - stop goes to IDLE and clears done and q.
- stop in any state: go to IDLE next edge. q=0, prescaler=0, tc=0, done=0, busy=0. A tc due on that edge is suppressed.
- start while RUN/HOLD: restart. Relatch inputs, q=0, prescaler=0, state RUN. No tc on that edge.
- Simultaneous start and stop: stop wins, go to IDLE.
- pause together with start from IDLE: enter RUN, then go to HOLD on the next edge if pause is still high.
- term, presc and mode changes have no effect until the next start.
- Wrap arithmetic is modulo 2**WIDTH only when term_l = 2**WIDTH-1. No overflow is otherwise possible.
- Reset asserted mid-run: immediate async return to the reset values. Deassertion is synchronised by the system reset bridge.

Optional Feature:
Macro COUNTER_SEQ_CAPTURE_EN.
- Defined: adds input cap (1 bit) and output cap_q (WIDTH) and cap_vld (1).
  - A rising edge of cap in RUN or HOLD copies q into cap_q with a 1-cycle cap_vld pulse. Latency is 2 cycles from the cap edge, because of edge detection and the register.
  - cap_q resets to 0 and holds its value otherwise.
  - A cap edge in IDLE or DONE is ignored.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
1. Reset mid-run: assert rst while q=5 -> q=0, busy=0, done=0, tc=0 asynchronously, before the next clk edge.
2. One-shot timing: term=3, presc=1, mode=0, start pulse at edge k.
   - q=1,2,3 at edges k+2, k+4, k+6.
   - tc high for exactly 1 cycle on the k+8 step; done=1; q stays 3.
3. Periodic with pause: term=4, presc=0, mode=1.
   - tc every 5 cycles.
   - Assert pause for 7 cycles at q=2 -> q frozen at 2, no tc; after release the next tc arrives 7 cycles later than nominal.
4. Stop/start priority:
   - stop and start together while q=2 -> IDLE, q=0, busy=0.
   - start alone in RUN at q=3 -> q=0, RUN, no tc.
5. Edge values:
   - term=0, presc=0 -> tc every cycle, q=0.
   - term=255 (WIDTH=8), presc=15 -> first tc 4096 cycles after start; in periodic mode q wraps to 0.
6. (COUNTER_SEQ_CAPTURE_EN) cap rising edge at q=7, presc=3 -> cap_q=7, cap_vld high for 1 cycle, 2 cycles later. A cap edge in IDLE -> no cap_vld.
